barrel_shift_pipe: RTL and testbench
====================================

// Module: barrel_shift_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter/rotator for the ALU datapath.
//  Successor to the 8-bit combinational rotator: generic WIDTH, five shift
//  modes, carry-out and zero flags, and optional per-stage pipelining.
//  Sits between operand select and the ALU result mux, with a valid/ready
//  handshake on both sides.
// PARAMETERS
//  WIDTH     8  data width in bits; must be a power of 2 and >= 2
//  PIPELINE  1  1 = register after each of the AMT_W mux stages;
//               0 = all stages combinational, one output register
//  AMT_W  (localparam) $clog2(WIDTH), the shift-amount width
// PORTS
//  clk        in   1      clock; all registers rise-edge triggered
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept an input beat this cycle
//  a          in   WIDTH  operand
//  amt        in   AMT_W  shift amount, 0..WIDTH-1
//  mode       in   3      000 ROR, 001 ROL, 010 LSR, 011 LSL, 100 ASR
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts the result
//  y          out  WIDTH  result
//  carry      out  1      last bit shifted or rotated out
//  zero       out  1      y == 0
// BEHAVIOUR
//  - Reset (rst_n low, async): every stage valid bit = 0; data and flag
//    registers = 0; outputs y=0, carry=0, zero=0, out_valid=0. in_ready
//    is 1 one cycle after reset releases.
//  - Stage k (k=0..AMT_W-1) shifts by 2^k when amt[k]=1. It carries
//    mode, remaining amt bits, partial data and partial carry forward.
//  - Latency from accepted input to out_valid: AMT_W cycles when
//    PIPELINE=1, 1 cycle when PIPELINE=0. Throughput is 1 beat/cycle
//    with no stalls.
//  - Handshake: a transfer happens when valid && ready. A stage loads
//    when it is empty or its own contents move on this cycle, so
//    in_ready = !full[0] || advance[0], and ready propagates back from
//    out_ready. While out_valid && !out_ready, y/carry/zero stay stable.
//    No beat is dropped or duplicated. in_ready never depends
//    combinationally on in_valid.
//  - Arithmetic: ROR/ROL wrap bits. LSR/LSL fill with 0. ASR fills with
//    a[WIDTH-1].
//  - Carry: LSR/ASR -> a[amt-1]; LSL -> a[WIDTH-amt];
//    ROR -> y[WIDTH-1]; ROL -> y[0].
//  - Boundary: amt=0 -> y=a, carry=0 in every mode. Illegal mode
//    (101..111) -> y=a, carry=0. zero is computed from the final y.
//  - Simultaneous in and out transfers in the same cycle with a full
//    pipe: both occur and occupancy is unchanged.
//  - Reset asserted mid-operation discards all in-flight beats.
// STRUCTURE
//  - alu_pkg: mode localparams (MODE_ROR..MODE_ASR) and the 3-bit mode
//    width, shared with the ALU control decode.
//  - Sub-module bs_stage: one mux level, parameters WIDTH and SHIFT
//    (=2^k), and an optional register with valid/ready. The top module
//    instantiates AMT_W copies with a generate loop and computes zero on
//    the final stage.
// TESTING (WIDTH=8, PIPELINE=1 unless noted)
//  1 ROR a=0x99 amt=4 -> y=0x99. a=0x19 amt=4 -> y=0x91.
//    a=0xC0 amt=4 -> y=0x0C, carry=0. Each arrives 3 cycles after accept.
//  2 LSL a=0xC0 amt=1 -> y=0x80, carry=1. ASR a=0x80 amt=3 -> y=0xF0,
//    carry=0. LSR a=0x01 amt=1 -> y=0x00, zero=1, carry=1.
//  3 Back-to-back stream of 16 random beats with out_ready=1 -> one
//    result per cycle, in order, matching the reference model.
//  4 out_ready held 0 for 6 cycles during the stream -> in_ready drops
//    once 3 beats are held; y stays stable; no loss or duplication after
//    release.
//  5 rst_n pulsed low with 2 beats in flight -> out_valid=0 and y=0
//    immediately (async). The first result after release comes from a
//    new input only.
//  6 PIPELINE=0, mode=3'b111, a=0x5A amt=2 -> y=0x5A, carry=0, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift/rotate mode encodings used by the barrel shifter
// and by the ALU control decode.
package alu_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_ROR = 3'b000;
    localparam logic [MODE_W-1:0] MODE_ROL = 3'b001;
    localparam logic [MODE_W-1:0] MODE_LSR = 3'b010;
    localparam logic [MODE_W-1:0] MODE_LSL = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ASR = 3'b100;

endpackage

// File: rtl/barrel_shift_pipe_if.sv
// Operand and result streams of the barrel shifter, each with a valid/ready handshake.
// The master drives operands and accepts results; the slave is the shifter itself.
interface barrel_shift_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int AMT_W = $clog2(WIDTH);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [AMT_W-1:0]  amt;
    logic [MODE_W-1:0] mode;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  y;
    logic              carry;
    logic              zero;

    modport master (
        output in_valid, a, amt, mode, out_ready,
        input  in_ready, out_valid, y, carry, zero
    );

    modport slave (
        input  in_valid, a, amt, mode, out_ready,
        output in_ready, out_valid, y, carry, zero
    );

endinterface

// File: rtl/barrel_shift_pipe_bs_stage.sv
// One barrel-shifter level: shifts by SHIFT when its amount bit is set, tracks the
// last bit moved out, and optionally registers the result behind a valid/ready slot.
module bs_stage
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int SHIFT = 1,
    parameter  bit REG   = 1'b1,
    localparam int AMT_W = $clog2(WIDTH),
    localparam int BIT   = $clog2(SHIFT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_carry,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [AMT_W-1:0]  in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_carry,
    output logic [MODE_W-1:0] out_mode,
    output logic [AMT_W-1:0]  out_amt
);

    logic [WIDTH-1:0] data_next;
    logic             carry_next;

    // Carry is only replaced when this level actually moves bits, so the final
    // value is whatever the last active level shifted or rotated out.
    always_comb begin
        data_next  = in_data;
        carry_next = in_carry;
        if (in_amt[BIT]) begin
            case (in_mode)
                MODE_ROR: begin
                    data_next  = {in_data[SHIFT-1:0], in_data[WIDTH-1:SHIFT]};
                    carry_next = in_data[SHIFT-1];
                end
                MODE_ROL: begin
                    data_next  = {in_data[WIDTH-SHIFT-1:0], in_data[WIDTH-1:WIDTH-SHIFT]};
                    carry_next = in_data[WIDTH-SHIFT];
                end
                MODE_LSR: begin
                    data_next  = {{SHIFT{1'b0}}, in_data[WIDTH-1:SHIFT]};
                    carry_next = in_data[SHIFT-1];
                end
                MODE_LSL: begin
                    data_next  = {in_data[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
                    carry_next = in_data[WIDTH-SHIFT];
                end
                MODE_ASR: begin
                    data_next  = {{SHIFT{in_data[WIDTH-1]}}, in_data[WIDTH-1:SHIFT]};
                    carry_next = in_data[SHIFT-1];
                end
                default: ;
            endcase
        end
    end

    generate
        if (REG) begin : g_reg
            logic              full_reg;
            logic [WIDTH-1:0]  data_reg;
            logic              carry_reg;
            logic [MODE_W-1:0] mode_reg;
            logic [AMT_W-1:0]  amt_reg;

            // Loads when empty or when the current occupant leaves this cycle.
            assign in_ready = !full_reg || out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    full_reg  <= 1'b0;
                    data_reg  <= '0;
                    carry_reg <= 1'b0;
                    mode_reg  <= '0;
                    amt_reg   <= '0;
                end else if (in_valid && in_ready) begin
                    full_reg  <= 1'b1;
                    data_reg  <= data_next;
                    carry_reg <= carry_next;
                    mode_reg  <= in_mode;
                    amt_reg   <= in_amt;
                end else if (out_ready) begin
                    full_reg  <= 1'b0;
                end
            end

            assign out_valid = full_reg;
            assign out_data  = data_reg;
            assign out_carry = carry_reg;
            assign out_mode  = mode_reg;
            assign out_amt   = amt_reg;
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;

            assign in_ready  = out_ready;
            assign out_valid = in_valid;
            assign out_data  = data_next;
            assign out_carry = carry_next;
            assign out_mode  = in_mode;
            assign out_amt   = in_amt;
        end
    endgenerate

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator: AMT_W binary-weighted shift levels chained by
// valid/ready, with carry-out and a zero flag on the final result.
module barrel_shift_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit PIPELINE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    barrel_shift_pipe_if.slave  bus
);

    localparam int AMT_W = $clog2(WIDTH);

    // Index gi is the input of level gi; index AMT_W is the result side.
    logic              st_valid [AMT_W+1];
    logic              st_ready [AMT_W+1];
    logic [WIDTH-1:0]  st_data  [AMT_W+1];
    logic              st_carry [AMT_W+1];
    logic [MODE_W-1:0] st_mode  [AMT_W+1];
    logic [AMT_W-1:0]  st_amt   [AMT_W+1];

    assign st_valid[0]  = bus.in_valid;
    assign st_data[0]   = bus.a;
    assign st_carry[0]  = 1'b0;
    assign st_mode[0]   = bus.mode;
    assign st_amt[0]    = bus.amt;
    assign bus.in_ready = st_ready[0];

    // Without per-level pipelining only the last level keeps its register.
    generate
        for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
            bs_stage #(
                .WIDTH (WIDTH),
                .SHIFT (1 << gi),
                .REG   (PIPELINE || (gi == AMT_W - 1))
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (st_valid[gi]),
                .in_ready  (st_ready[gi]),
                .in_data   (st_data[gi]),
                .in_carry  (st_carry[gi]),
                .in_mode   (st_mode[gi]),
                .in_amt    (st_amt[gi]),
                .out_valid (st_valid[gi+1]),
                .out_ready (st_ready[gi+1]),
                .out_data  (st_data[gi+1]),
                .out_carry (st_carry[gi+1]),
                .out_mode  (st_mode[gi+1]),
                .out_amt   (st_amt[gi+1])
            );
        end
    endgenerate

    assign st_ready[AMT_W] = bus.out_ready;
    assign bus.out_valid   = st_valid[AMT_W];
    assign bus.y           = st_data[AMT_W];
    assign bus.carry       = st_carry[AMT_W];
    // Gated by valid so an empty output (including after reset) never reports zero.
    assign bus.zero        = st_valid[AMT_W] && (st_data[AMT_W] == '0);

    logic unused_tail;
    assign unused_tail = ^{st_mode[AMT_W], st_amt[AMT_W]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe: a pipelined and a flat instance,
// expected results queued on accept and compared when each result transfers.
module tb_barrel_shift_pipe;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] y;
        logic       carry;
        logic       zero;
        int         cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    barrel_shift_pipe_if #(.WIDTH(8)) b0 ();
    barrel_shift_pipe_if #(.WIDTH(8)) b1 ();

    barrel_shift_pipe #(.WIDTH(8), .PIPELINE(1'b1)) u_dut_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    barrel_shift_pipe #(.WIDTH(8), .PIPELINE(1'b0)) u_dut_flat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];

    function automatic exp_t mk(input logic [7:0] y, input logic c, input logic z);
        exp_t r;
        r.y = y; r.carry = c; r.zero = z; r.cyc = 0;
        return r;
    endfunction

    // Direct whole-amount reference, written from the operation definitions.
    function automatic exp_t ref_model(input logic [7:0] av, input logic [2:0] n, input logic [2:0] m);
        exp_t r;
        int   k;
        k       = int'(n);
        r.y     = av;
        r.carry = 1'b0;
        r.cyc   = 0;
        if (k != 0) begin
            case (m)
                3'b000: begin r.y = (av >> k) | (av << (8 - k)); r.carry = r.y[7]; end
                3'b001: begin r.y = (av << k) | (av >> (8 - k)); r.carry = r.y[0]; end
                3'b010: begin r.y = av >> k; r.carry = av[k-1]; end
                3'b011: begin r.y = av << k; r.carry = av[8-k]; end
                3'b100: begin r.y = 8'($signed(av) >>> k); r.carry = av[k-1]; end
                default: ;
            endcase
        end
        r.zero = (r.y == 8'h00);
        return r;
    endfunction

    // One clock of stimulus on the selected instance; records what transferred.
    task automatic drive_cycle(input bit sel, input logic v, input logic [7:0] av,
                               input logic [2:0] nv, input logic [2:0] mv, input logic ordy,
                               input exp_t e, output bit in_fire, output bit out_fire,
                               output bit ov, output exp_t got, output logic ir);
        @(negedge clk);
        if (!sel) begin
            b0.in_valid = v; b0.a = av; b0.amt = nv; b0.mode = mv; b0.out_ready = ordy;
            b1.in_valid = 1'b0; b1.out_ready = 1'b1;
        end else begin
            b1.in_valid = v; b1.a = av; b1.amt = nv; b1.mode = mv; b1.out_ready = ordy;
            b0.in_valid = 1'b0; b0.out_ready = 1'b1;
        end
        #1;
        ir        = sel ? b1.in_ready  : b0.in_ready;
        ov        = sel ? b1.out_valid : b0.out_valid;
        got.y     = sel ? b1.y     : b0.y;
        got.carry = sel ? b1.carry : b0.carry;
        got.zero  = sel ? b1.zero  : b0.zero;
        got.cyc   = cyc;
        in_fire   = v && ir;
        out_fire  = ov && ordy;
        if (in_fire) begin
            e.cyc = cyc;
            if (sel) q1.push_back(e);
            else     q0.push_back(e);
        end
        cyc++;
    endtask

    task automatic test_reset();
        b0.in_valid = 1'b0; b0.out_ready = 1'b0; b0.a = '0; b0.amt = '0; b0.mode = '0;
        b1.in_valid = 1'b0; b1.out_ready = 1'b0; b1.a = '0; b1.amt = '0; b1.mode = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (b0.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", b0.out_valid); end
        n_cmp++; if (b0.y !== 8'h00) begin n_err++; $display("FAIL reset_y: got %h expected 00", b0.y); end
        n_cmp++; if (b0.carry !== 1'b0) begin n_err++; $display("FAIL reset_carry: got %b expected 0", b0.carry); end
        n_cmp++; if (b0.zero !== 1'b0) begin n_err++; $display("FAIL reset_zero: got %b expected 0", b0.zero); end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (b0.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", b0.in_ready); end
        $display("reset: outputs idle, in_ready=%b", b0.in_ready);
    endtask

    task automatic test_rotate();
        logic [7:0] av [3] = '{8'h99, 8'h19, 8'hC0};
        exp_t       ev [3];
        int         i = 0;
        bit         inf, of, ov;
        logic       ir;
        exp_t       got, ex;
        ev[0] = mk(8'h99, 1'b1, 1'b0);
        ev[1] = mk(8'h91, 1'b1, 1'b0);
        ev[2] = mk(8'h0C, 1'b0, 1'b0);
        for (int c = 0; c < 20 && (i < 3 || q0.size() != 0); c++) begin
            drive_cycle(1'b0, i < 3, av[i < 3 ? i : 0], 3'd4, MODE_ROR, 1'b1, ev[i < 3 ? i : 0], inf, of, ov, got, ir);
            if (inf) i++;
            if (of) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL ror_spurious: got y=%h with nothing pending", got.y);
                end else begin
                    ex = q0.pop_front();
                    $display("ror: y=%h c=%b z=%b (expected %h %b %b) latency %0d", got.y, got.carry, got.zero, ex.y, ex.carry, ex.zero, got.cyc - ex.cyc);
                    n_cmp++;
                    if ({got.y, got.carry, got.zero} !== {ex.y, ex.carry, ex.zero}) begin
                        n_err++; $display("FAIL ror_value: got y=%h c=%b z=%b expected y=%h c=%b z=%b", got.y, got.carry, got.zero, ex.y, ex.carry, ex.zero);
                    end
                    n_cmp++;
                    if (got.cyc - ex.cyc != 3) begin n_err++; $display("FAIL ror_latency: got %0d expected 3", got.cyc - ex.cyc); end
                end
            end
        end
        n_cmp++; if (i != 3 || q0.size() != 0) begin n_err++; $display("FAIL ror_drain: sent %0d pending %0d expected 3/0", i, q0.size()); end
    endtask

    task automatic test_shift();
        logic [7:0] av [4] = '{8'hC0, 8'h80, 8'h01, 8'h3C};
        logic [2:0] nv [4] = '{3'd1, 3'd3, 3'd1, 3'd0};
        logic [2:0] mv [4] = '{MODE_LSL, MODE_ASR, MODE_LSR, MODE_ROL};
        exp_t       ev [4];
        int         i = 0;
        bit         inf, of, ov;
        logic       ir;
        exp_t       got, ex;
        ev[0] = mk(8'h80, 1'b1, 1'b0);
        ev[1] = mk(8'hF0, 1'b0, 1'b0);
        ev[2] = mk(8'h00, 1'b1, 1'b1);
        ev[3] = mk(8'h3C, 1'b0, 1'b0);
        for (int c = 0; c < 20 && (i < 4 || q0.size() != 0); c++) begin
            drive_cycle(1'b0, i < 4, av[i < 4 ? i : 0], nv[i < 4 ? i : 0], mv[i < 4 ? i : 0], 1'b1, ev[i < 4 ? i : 0], inf, of, ov, got, ir);
            if (inf) i++;
            if (of) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL shift_spurious: got y=%h with nothing pending", got.y);
                end else begin
                    ex = q0.pop_front();
                    $display("shift: y=%h c=%b z=%b (expected %h %b %b)", got.y, got.carry, got.zero, ex.y, ex.carry, ex.zero);
                    n_cmp++;
                    if ({got.y, got.carry, got.zero} !== {ex.y, ex.carry, ex.zero}) begin
                        n_err++; $display("FAIL shift_value: got y=%h c=%b z=%b expected y=%h c=%b z=%b", got.y, got.carry, got.zero, ex.y, ex.carry, ex.zero);
                    end
                end
            end
        end
        n_cmp++; if (i != 4 || q0.size() != 0) begin n_err++; $display("FAIL shift_drain: sent %0d pending %0d expected 4/0", i, q0.size()); end
    endtask

    task automatic test_back_to_back();
        int         sent = 0, recv = 0;
        bit         inf, of, ov;
        logic       ir;
        exp_t       got, ex;
        logic [7:0] av;
        logic [2:0] nv, mv;
        av = 8'($urandom); nv = 3'($urandom_range(0, 7)); mv = 3'($urandom_range(0, 7));
        for (int c = 0; c < 40 && recv < 16; c++) begin
            drive_cycle(1'b0, sent < 16, av, nv, mv, 1'b1, ref_model(av, nv, mv), inf, of, ov, got, ir);
            n_cmp++; if (ir !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b expected 1", ir); end
            if (inf) begin
                sent++;
                av = 8'($urandom); nv = 3'($urandom_range(0, 7)); mv = 3'($urandom_range(0, 7));
            end
            if (of) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL b2b_spurious: got y=%h with nothing pending", got.y);
                end else begin
                    ex = q0.pop_front();
                    recv++;
                    $display("b2b[%0d]: y=%h c=%b z=%b (expected %h %b %b)", recv, got.y, got.carry, got.zero, ex.y, ex.carry, ex.zero);
                    n_cmp++;
                    if ({got.y, got.carry, got.zero} !== {ex.y, ex.carry, ex.zero}) begin
                        n_err++; $display("FAIL b2b_value: got y=%h c=%b z=%b expected y=%h c=%b z=%b", got.y, got.carry, got.zero, ex.y, ex.carry, ex.zero);
                    end
                    n_cmp++;
                    if (got.cyc - ex.cyc != 3) begin n_err++; $display("FAIL b2b_latency: got %0d expected 3", got.cyc - ex.cyc); end
                end
            end
        end
        n_cmp++; if (recv != 16 || q0.size() != 0) begin n_err++; $display("FAIL b2b_count: got %0d results expected 16", recv); end
    endtask

    task automatic test_stall();
        int         sent = 0, recv = 0, occ, drops = 0;
        bit         inf, of, ov, held_set = 1'b0;
        logic       ir, ordy, exp_ir;
        exp_t       got, ex;
        logic [7:0] av, held_y = 8'h00;
        logic [2:0] nv, mv;
        av = 8'($urandom); nv = 3'($urandom_range(1, 7)); mv = 3'($urandom_range(0, 4));
        for (int c = 0; c < 60 && recv < 12; c++) begin
            ordy = !(c >= 4 && c < 10);
            occ  = q0.size();
            drive_cycle(1'b0, sent < 12, av, nv, mv, ordy, ref_model(av, nv, mv), inf, of, ov, got, ir);
            exp_ir = ordy || (occ < 3);
            n_cmp++;
            if (ir !== exp_ir) begin n_err++; $display("FAIL stall_in_ready: got %b expected %b (held %0d)", ir, exp_ir, occ); end
            if (!ordy && !ir) drops++;
            if (!ordy && ov) begin
                if (!held_set) begin
                    held_y = got.y; held_set = 1'b1;
                end else begin
                    n_cmp++;
                    if (got.y !== held_y) begin n_err++; $display("FAIL stall_hold: got y=%h expected %h", got.y, held_y); end
                end
            end
            if (inf) begin
                sent++;
                av = 8'($urandom); nv = 3'($urandom_range(1, 7)); mv = 3'($urandom_range(0, 4));
            end
            if (of) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL stall_spurious: got y=%h with nothing pending", got.y);
                end else begin
                    ex = q0.pop_front();
                    recv++;
                    $display("stall[%0d]: y=%h c=%b z=%b (expected %h %b %b)", recv, got.y, got.carry, got.zero, ex.y, ex.carry, ex.zero);
                    n_cmp++;
                    if ({got.y, got.carry, got.zero} !== {ex.y, ex.carry, ex.zero}) begin
                        n_err++; $display("FAIL stall_value: got y=%h c=%b z=%b expected y=%h c=%b z=%b", got.y, got.carry, got.zero, ex.y, ex.carry, ex.zero);
                    end
                end
            end
        end
        n_cmp++; if (drops == 0) begin n_err++; $display("FAIL stall_backpressure: in_ready low cycles got 0 expected >0"); end
        n_cmp++; if (recv != 12 || q0.size() != 0) begin n_err++; $display("FAIL stall_count: got %0d results expected 12", recv); end
    endtask

    task automatic test_async_reset();
        logic [7:0] av [2] = '{8'h81, 8'h42};
        logic [2:0] mv [2] = '{MODE_ROL, MODE_LSR};
        int         sent = 0;
        bit         inf, of, ov, seen = 1'b0, stray = 1'b0;
        logic       ir;
        exp_t       got, ex;
        for (int c = 0; c < 10 && !seen; c++) begin
            drive_cycle(1'b0, sent < 2, av[sent < 2 ? sent : 0], 3'd1, mv[sent < 2 ? sent : 0], 1'b0,
                        ref_model(av[sent < 2 ? sent : 0], 3'd1, mv[sent < 2 ? sent : 0]), inf, of, ov, got, ir);
            if (inf) sent++;
            seen = ov;
        end
        n_cmp++; if (!seen || got.y !== 8'h03) begin n_err++; $display("FAIL rst_preload: got valid=%b y=%h expected 1/03", seen, got.y); end
        #2 rst_n = 1'b0;
        #1;
        $display("async reset: out_valid=%b y=%h carry=%b zero=%b", b0.out_valid, b0.y, b0.carry, b0.zero);
        n_cmp++; if (b0.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", b0.out_valid); end
        n_cmp++; if (b0.y !== 8'h00) begin n_err++; $display("FAIL rst_y: got %h expected 00", b0.y); end
        n_cmp++; if (b0.carry !== 1'b0) begin n_err++; $display("FAIL rst_carry: got %b expected 0", b0.carry); end
        n_cmp++; if (b0.zero !== 1'b0) begin n_err++; $display("FAIL rst_zero: got %b expected 0", b0.zero); end
        q0.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b0, 1'b0, 8'h00, 3'd0, MODE_ROR, 1'b1, mk(8'h00, 1'b0, 1'b1), inf, of, ov, got, ir);
            if (ov) stray = 1'b1;
        end
        n_cmp++; if (stray) begin n_err++; $display("FAIL rst_flushed: got out_valid=1 expected 0 after reset"); end
        seen = 1'b0;
        sent = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            drive_cycle(1'b0, sent == 0, 8'h90, 3'd2, MODE_ASR, 1'b1, mk(8'hE4, 1'b0, 1'b0), inf, of, ov, got, ir);
            if (inf) sent++;
            seen = of;
        end
        if (!seen || q0.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL rst_new_beat: got no result expected y=e4");
        end else begin
            ex = q0.pop_front();
            $display("after reset: y=%h c=%b z=%b (expected %h %b %b)", got.y, got.carry, got.zero, ex.y, ex.carry, ex.zero);
            n_cmp++;
            if ({got.y, got.carry, got.zero} !== {ex.y, ex.carry, ex.zero}) begin
                n_err++; $display("FAIL rst_new_beat: got y=%h c=%b z=%b expected y=%h c=%b z=%b", got.y, got.carry, got.zero, ex.y, ex.carry, ex.zero);
            end
        end
    endtask

    task automatic test_flat_illegal();
        logic [7:0] av [2] = '{8'h5A, 8'h83};
        logic [2:0] nv [2] = '{3'd2, 3'd7};
        logic [2:0] mv [2] = '{3'b111, MODE_LSL};
        exp_t       ev [2];
        int         i = 0;
        bit         inf, of, ov;
        logic       ir;
        exp_t       got, ex;
        ev[0] = mk(8'h5A, 1'b0, 1'b0);
        ev[1] = mk(8'h80, 1'b1, 1'b0);
        for (int c = 0; c < 10 && (i < 2 || q1.size() != 0); c++) begin
            drive_cycle(1'b1, i < 2, av[i < 2 ? i : 0], nv[i < 2 ? i : 0], mv[i < 2 ? i : 0], 1'b1, ev[i < 2 ? i : 0], inf, of, ov, got, ir);
            if (inf) i++;
            if (of) begin
                if (q1.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL flat_spurious: got y=%h with nothing pending", got.y);
                end else begin
                    ex = q1.pop_front();
                    $display("flat: y=%h c=%b z=%b (expected %h %b %b) latency %0d", got.y, got.carry, got.zero, ex.y, ex.carry, ex.zero, got.cyc - ex.cyc);
                    n_cmp++;
                    if ({got.y, got.carry, got.zero} !== {ex.y, ex.carry, ex.zero}) begin
                        n_err++; $display("FAIL flat_value: got y=%h c=%b z=%b expected y=%h c=%b z=%b", got.y, got.carry, got.zero, ex.y, ex.carry, ex.zero);
                    end
                    n_cmp++;
                    if (got.cyc - ex.cyc != 1) begin n_err++; $display("FAIL flat_latency: got %0d expected 1", got.cyc - ex.cyc); end
                end
            end
        end
        n_cmp++; if (i != 2 || q1.size() != 0) begin n_err++; $display("FAIL flat_drain: sent %0d pending %0d expected 2/0", i, q1.size()); end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_shift();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_flat_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
